// File: rtl/rv32_pipe_pkg.sv
// Shared encodings for the RV32I multicycle pipe stages: stage FSM states
// and funct3 load/store size codes.
package rv32_pipe_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BEF  = 3'd1,
        S_ACCESS    = 3'd2,
        S_SENDING   = 3'd3,
        S_WAIT_SEND = 3'd4
    } pipe_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: store strobes and replicated write
// data, plus load byte/half extraction with sign or zero extension.
module mem_lane_align
    import rv32_pipe_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [31:0] w_shifted;

    // Bring the addressed byte/half down to lane 0 before extending.
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_sdata;
        o_ldata = i_rdata;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_wstrb = 4'b0001 << i_offset;
                o_wdata = {4{i_sdata[7:0]}};
                o_ldata = {{24{(i_funct3 == F3_B) & w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_H, F3_HU: begin
                o_wstrb = 4'b0011 << i_offset;
                o_wdata = {2{i_sdata[15:0]}};
                o_ldata = {{16{(i_funct3 == F3_H) & w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the multicycle RV32I pipe: latches an execute result, runs the
// data-memory access over req/ack, hands wb_* to writeBack. Option: MEM_MISALIGN_CHECK_EN.
module mem_access_stage
    import rv32_pipe_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_IDX = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               startSig,
    input  logic               beforePipReadyToSend,
    input  logic               nextPipReadyToRcv,
    output logic               curPipReadyToRcv,
    output logic               curPipReadyToSend,
    input  logic               ex_valid,
    input  logic [REG_IDX-1:0] ex_rd,
    input  logic [XLEN-1:0]    ex_alu,
    input  logic [XLEN-1:0]    ex_sdata,
    input  logic               ex_ld,
    input  logic               ex_st,
    input  logic [2:0]         ex_funct3,
    output logic               mem_req,
    output logic               mem_we,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    output logic [3:0]         mem_wstrb,
    input  logic               mem_ack,
    input  logic [XLEN-1:0]    mem_rdata,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic               misalign_o,
`endif
    output logic               wb_valid,
    output logic [REG_IDX-1:0] wb_idx,
    output logic [XLEN-1:0]    wb_val,
    output logic               wb_en_valid,
    output logic               wb_en_idx,
    output logic               wb_en_data
);

    pipe_state_t        r_state;
    pipe_state_t        w_next_state;
    pipe_state_t        w_accept_state;
    logic               w_accept;
    logic               w_sending;
    logic               w_misalign;
    logic [XLEN-1:0]    w_ldata;

    logic [REG_IDX-1:0] r_rd;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_sdata;
    logic [XLEN-1:0]    r_val;
    logic [2:0]         r_funct3;
    logic               r_ld;
    logic               r_st;
    logic               r_wb_valid;

`ifdef MEM_MISALIGN_CHECK_EN
    logic               r_misalign;

    assign w_misalign = (ex_ld | ex_st) &
                        ((((ex_funct3 == F3_H) | (ex_funct3 == F3_HU)) & ex_alu[0]) |
                         ((ex_funct3 == F3_W) & (ex_alu[1:0] != 2'b00)));
    assign misalign_o = w_sending & r_misalign;

    always_ff @(posedge clk) begin
        if (w_accept) r_misalign <= w_misalign;
    end
`else
    assign w_misalign = 1'b0;
`endif

    mem_lane_align u_lane_align (
        .i_offset (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .i_sdata  (r_sdata),
        .i_rdata  (mem_rdata),
        .o_wstrb  (mem_wstrb),
        .o_wdata  (mem_wdata),
        .o_ldata  (w_ldata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_sending         = (r_state == S_SENDING) | (r_state == S_WAIT_SEND);
        curPipReadyToSend = w_sending;
        curPipReadyToRcv  = (r_state == S_WAIT_BEF) | (w_sending & nextPipReadyToRcv);
        w_accept          = curPipReadyToRcv & beforePipReadyToSend;
        w_accept_state    = ((ex_ld | ex_st) & ~w_misalign) ? S_ACCESS : S_SENDING;
        mem_req           = (r_state == S_ACCESS);
        mem_we            = mem_req & r_st;
        wb_en_valid       = w_sending & nextPipReadyToRcv;
        wb_en_idx         = wb_en_valid;
        wb_en_data        = wb_en_valid;
        w_next_state      = r_state;
        case (r_state)
            S_IDLE:     if (startSig) w_next_state = S_WAIT_BEF;
            S_WAIT_BEF: if (w_accept) w_next_state = w_accept_state;
            S_ACCESS:   if (mem_ack)  w_next_state = S_SENDING;
            S_SENDING, S_WAIT_SEND: begin
                if (!nextPipReadyToRcv) w_next_state = S_WAIT_SEND;
                else if (w_accept)      w_next_state = w_accept_state;
                else                    w_next_state = S_WAIT_BEF;
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    // NOTE: transaction registers carry no reset; the FSM guarantees they are
    // written before anything downstream can observe them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd       <= ex_rd;
            r_addr     <= ex_alu;
            r_sdata    <= ex_sdata;
            r_funct3   <= ex_funct3;
            r_ld       <= ex_ld;
            r_st       <= ex_st;
            r_wb_valid <= ex_valid & ~ex_st & ~w_misalign;
            r_val      <= ex_alu;
        end else if (mem_req && mem_ack && r_ld) begin
            r_val      <= w_ldata;
        end
    end

    assign mem_addr = {r_addr[XLEN-1:2], 2'b00};
    assign wb_valid = w_sending & r_wb_valid;
    assign wb_idx   = r_rd;
    assign wb_val   = r_val;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: ALU pass-through, loads,
// stores, writeBack stall, reset mid-access and the misaligned-access option.
module tb_mem_access_stage;
    import rv32_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        startSig;
    logic        beforePipReadyToSend;
    logic        nextPipReadyToRcv;
    logic        curPipReadyToRcv;
    logic        curPipReadyToSend;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu;
    logic [31:0] ex_sdata;
    logic        ex_ld;
    logic        ex_st;
    logic [2:0]  ex_funct3;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif
    logic        wb_valid;
    logic [4:0]  wb_idx;
    logic [31:0] wb_val;
    logic        wb_en_valid;
    logic        wb_en_idx;
    logic        wb_en_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .startSig             (startSig),
        .beforePipReadyToSend (beforePipReadyToSend),
        .nextPipReadyToRcv    (nextPipReadyToRcv),
        .curPipReadyToRcv     (curPipReadyToRcv),
        .curPipReadyToSend    (curPipReadyToSend),
        .ex_valid             (ex_valid),
        .ex_rd                (ex_rd),
        .ex_alu               (ex_alu),
        .ex_sdata             (ex_sdata),
        .ex_ld                (ex_ld),
        .ex_st                (ex_st),
        .ex_funct3            (ex_funct3),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_wstrb            (mem_wstrb),
        .mem_ack              (mem_ack),
        .mem_rdata            (mem_rdata),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o           (misalign_o),
`endif
        .wb_valid             (wb_valid),
        .wb_idx               (wb_idx),
        .wb_val               (wb_val),
        .wb_en_valid          (wb_en_valid),
        .wb_en_idx            (wb_en_idx),
        .wb_en_data           (wb_en_data)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one execute transaction for a single edge; returns settled after it.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd);
        ex_ld = ld; ex_st = st; ex_funct3 = f3; ex_valid = 1'b1;
        ex_rd = rd; ex_alu = alu; ex_sdata = sd;
        beforePipReadyToSend = 1'b1;
        step();
        beforePipReadyToSend = 1'b0;
        #1;
    endtask

    task automatic ack_now(input logic [31:0] rdata);
        mem_ack = 1'b1; mem_rdata = rdata;
        step();
        mem_ack = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; startSig = 1'b0; beforePipReadyToSend = 1'b0; nextPipReadyToRcv = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_alu = '0; ex_sdata = '0; ex_ld = 1'b0; ex_st = 1'b0;
        ex_funct3 = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_en", 32'(wb_en_valid), 32'd0);
        check("rst_rcv", 32'(curPipReadyToRcv), 32'd0);
        rst = 1'b0;
        step();
        check("idle_no_start_rcv", 32'(curPipReadyToRcv), 32'd0);
        startSig = 1'b1;
        step();
        startSig = 1'b0;
        #1;
        check("waitbef_rcv", 32'(curPipReadyToRcv), 32'd1);
        nextPipReadyToRcv = 1'b1;

        // ALU op: one-cycle latency, single wb_en pulse
        issue(1'b0, 1'b0, F3_W, 5'd5, 32'h0000_1234, 32'h0);
        check("add_send", 32'(curPipReadyToSend), 32'd1);
        check("add_wb_val", wb_val, 32'h0000_1234);
        check("add_wb_idx", 32'(wb_idx), 32'd5);
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_wb_en", {29'd0, wb_en_valid, wb_en_idx, wb_en_data}, 32'h7);
        check("add_no_req", 32'(mem_req), 32'd0);
        step();
        check("add_en_drop", 32'(wb_en_valid), 32'd0);
        check("add_back_waitbef", 32'(curPipReadyToRcv), 32'd1);

        // LB with sign, ack in the third request cycle
        issue(1'b1, 1'b0, F3_B, 5'd7, 32'h0000_0102, 32'h0);
        check("lb_req_c1", 32'(mem_req), 32'd1);
        check("lb_addr", mem_addr, 32'h0000_0100);
        check("lb_we", 32'(mem_we), 32'd0);
        step();
        check("lb_req_c2", 32'(mem_req), 32'd1);
        step();
        check("lb_req_c3", 32'(mem_req), 32'd1);
        ack_now(32'h0080_0000);
        check("lb_req_drop", 32'(mem_req), 32'd0);
        check("lb_wb_val", wb_val, 32'hFFFF_FF80);
        check("lb_wb_idx", 32'(wb_idx), 32'd7);
        check("lb_wb_valid", 32'(wb_valid), 32'd1);
        check("lb_wb_en", 32'(wb_en_valid), 32'd1);
        step();

        // LHU / LH extraction
        issue(1'b1, 1'b0, F3_HU, 5'd8, 32'h0000_0102, 32'h0);
        ack_now(32'h8001_0000);
        check("lhu_wb_val", wb_val, 32'h0000_8001);
        step();
        issue(1'b1, 1'b0, F3_H, 5'd8, 32'h0000_0100, 32'h0);
        ack_now(32'h1234_8001);
        check("lh_wb_val", wb_val, 32'hFFFF_8001);
        step();

        // Stores: strobes, replicated data, no rd write
        issue(1'b0, 1'b1, F3_B, 5'd6, 32'h0000_0103, 32'h0000_00AB);
        check("sb_wstrb", 32'(mem_wstrb), 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_we", 32'(mem_we), 32'd1);
        check("sb_addr", mem_addr, 32'h0000_0100);
        ack_now(32'h0);
        check("sb_wb_valid", 32'(wb_valid), 32'd0);
        check("sb_send", 32'(curPipReadyToSend), 32'd1);
        step();
        issue(1'b0, 1'b1, F3_H, 5'd6, 32'h0000_0102, 32'h1234_CDEF);
        check("sh_wstrb", 32'(mem_wstrb), 32'hC);
        check("sh_wdata", mem_wdata, 32'hCDEF_CDEF);
        ack_now(32'h0);
        step();

`ifdef MEM_MISALIGN_CHECK_EN
        issue(1'b1, 1'b0, F3_W, 5'd9, 32'h0000_0101, 32'h0);
        check("mis_flag", 32'(misalign_o), 32'd1);
        check("mis_no_req", 32'(mem_req), 32'd0);
        check("mis_wb_valid", 32'(wb_valid), 32'd0);
        check("mis_send", 32'(curPipReadyToSend), 32'd1);
        step();
`else
        issue(1'b1, 1'b0, F3_W, 5'd9, 32'h0000_0101, 32'h0);
        check("lw_forced_align", mem_addr, 32'h0000_0100);
        check("lw_wstrb", 32'(mem_wstrb), 32'hF);
        ack_now(32'hDEAD_BEEF);
        check("lw_wb_val", wb_val, 32'hDEAD_BEEF);
        step();
`endif

        // writeBack stall with an execute op pending
        nextPipReadyToRcv = 1'b0;
        issue(1'b0, 1'b0, F3_W, 5'd3, 32'h0000_0055, 32'h0);
        check("stall_send", 32'(curPipReadyToSend), 32'd1);
        check("stall_en0", 32'(wb_en_valid), 32'd0);
        ex_rd = 5'd4; ex_alu = 32'h0000_0066; beforePipReadyToSend = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_en", 32'(wb_en_valid), 32'd0);
            check("stall_rcv", 32'(curPipReadyToRcv), 32'd0);
            check("stall_val", wb_val, 32'h0000_0055);
        end
        nextPipReadyToRcv = 1'b1;
        #1;
        check("release_en", 32'(wb_en_valid), 32'd1);
        check("release_rcv", 32'(curPipReadyToRcv), 32'd1);
        step();
        beforePipReadyToSend = 1'b0;
        #1;
        check("b2b_val", wb_val, 32'h0000_0066);
        check("b2b_idx", 32'(wb_idx), 32'd4);
        check("b2b_en", 32'(wb_en_valid), 32'd1);
        step();

        // x0 destination passes through
        issue(1'b0, 1'b0, F3_W, 5'd0, 32'h0000_0077, 32'h0);
        check("x0_idx", 32'(wb_idx), 32'd0);
        check("x0_valid", 32'(wb_valid), 32'd1);
        step();

        // reset while the bus request is outstanding
        issue(1'b1, 1'b0, F3_W, 5'd9, 32'h0000_0200, 32'h0);
        check("rstacc_req", 32'(mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rstacc_req_drop", 32'(mem_req), 32'd0);
        check("rstacc_no_en", 32'(wb_en_valid), 32'd0);
        check("rstacc_no_send", 32'(curPipReadyToSend), 32'd0);
        step();
        check("rstacc_idle_req", 32'(mem_req), 32'd0);
        check("rstacc_idle_en", 32'(wb_en_valid), 32'd0);
        check("rstacc_idle_rcv", 32'(curPipReadyToRcv), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
